// File: rtl/cotm32_pkg.sv
// Shared LSU/data-memory types and helpers.
package cotm32_pkg;

  localparam int BYTE_WIDTH = 8;

  // Access type from the load-store unit; unlisted encodings mean "no access".
  typedef enum logic [3:0] {
    LSU_NONE    = 4'd0,
    LSU_LOAD_B  = 4'd1,
    LSU_LOAD_H  = 4'd2,
    LSU_LOAD_W  = 4'd3,
    LSU_LOAD_BU = 4'd4,
    LSU_LOAD_HU = 4'd5,
    LSU_STORE_B = 4'd6,
    LSU_STORE_H = 4'd7,
    LSU_STORE_W = 4'd8
  } lsu_ls_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} dmem_state_t;

  // Byte count of an access; 0 for anything that is not a memory op.
  function automatic logic [2:0] lsu_size(lsu_ls_t op);
    case (op)
      LSU_LOAD_B, LSU_LOAD_BU, LSU_STORE_B: return 3'd1;
      LSU_LOAD_H, LSU_LOAD_HU, LSU_STORE_H: return 3'd2;
      LSU_LOAD_W, LSU_STORE_W:              return 3'd4;
      default:                              return 3'd0;
    endcase
  endfunction

  function automatic logic lsu_is_load(lsu_ls_t op);
    return op inside {LSU_LOAD_B, LSU_LOAD_H, LSU_LOAD_W, LSU_LOAD_BU, LSU_LOAD_HU};
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane shifter: moves store data/strobes up into the addressed lanes,
// moves read data down to lane 0, and flags size/offset misalignment.
module dmem_align
  import cotm32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              off,
  input  logic [2:0]              size,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [DATA_WIDTH-1:0]   wdata_sh,
  output logic [DATA_WIDTH/8-1:0] wstrb_sh,
  output logic [DATA_WIDTH-1:0]   rdata_sh,
  output logic                    misaligned
);

  assign wdata_sh   = wdata << {off, 3'b000};
  assign wstrb_sh   = wstrb << off;
  assign rdata_sh   = rdata >> {off, 3'b000};
  assign misaligned = (size == 3'd2 && off[0]) || (size == 3'd4 && off != 2'd0);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory bus controller: one LSU access at a time over a valid/ready
// request channel plus a read-response channel, with a bus timeout.
module dmem_ctrl
  import cotm32_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req,
  input  lsu_ls_t                 i_op,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_we,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_done,
  output logic                    o_stall,
  output logic                    o_fault_misaligned,
  output logic                    o_fault_bus,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
  output logic                    o_mem_we,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int SW = DATA_WIDTH / BYTE_WIDTH;
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  dmem_state_t     state_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      off_q;
  logic            load_q;
  logic            fault_bus_q;

  logic [2:0]            size;
  logic                  is_load;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic [SW-1:0]         wstrb_sh;
  logic                  misaligned;
  logic                  idle_req;
  logic                  accept;
  logic                  timeout_hit;

  assign size    = lsu_size(i_op);
  assign is_load = lsu_is_load(i_op);

  // The shifter sees the live offset while accepting and the latched one
  // while a load response is pending, so one instance serves both paths.
  assign off = (state_q == IDLE) ? i_addr[1:0] : off_q;

  dmem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off        (off),
    .size       (size),
    .wdata      (i_wdata),
    .wstrb      (is_load ? '0 : i_wstrb),
    .rdata      (i_mem_rdata),
    .wdata_sh   (wdata_sh),
    .wstrb_sh   (wstrb_sh),
    .rdata_sh   (rdata_sh),
    .misaligned (misaligned)
  );

  assign idle_req    = i_req && (state_q == IDLE) && (size != 3'd0);
  assign accept      = idle_req && !misaligned;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);

  // Misaligned and non-access requests retire immediately from IDLE.
  assign o_done = (state_q == DONE) ||
                  (i_req && (state_q == IDLE) && (size == 3'd0 || misaligned));
  assign o_fault_misaligned = idle_req && misaligned;
  assign o_fault_bus        = fault_bus_q;
  assign o_stall            = i_req && !o_done;

  // Access FSM with timeout counter; progress on the bus wins over timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      load_q      <= 1'b0;
      fault_bus_q <= 1'b0;
      o_rdata     <= '0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_mem_we    <= 1'b0;
    end else begin
      fault_bus_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            off_q       <= i_addr[1:0];
            load_q      <= is_load;
            cnt_q       <= '0;
            o_mem_valid <= 1'b1;
            o_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            o_mem_wdata <= wdata_sh;
            o_mem_wstrb <= wstrb_sh;
            o_mem_we    <= i_we;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            cnt_q       <= cnt_q + CW'(1);
            state_q     <= load_q ? RESP : DONE;
          end else if (timeout_hit) begin
            o_mem_valid <= 1'b0;
            o_rdata     <= '0;
            fault_bus_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (i_mem_rvalid) begin
            o_rdata <= rdata_sh;
            state_q <= DONE;
          end else if (timeout_hit) begin
            o_rdata     <= '0;
            fault_bus_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
